lv_int_status_agg: RTL

//  Parametrised successor of the LV/HV status merge + mask stage. Merges NUM_REG LV status words

---
 rtl/lv_int_status_agg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lv_int_status_agg.sv
// LV/HV status merge with sticky latching, W1C clear, per-bit fault masking and interrupt generation.
// Optional build macro LV_INT_RD_CLR_EN: reads also clear the addressed sticky word.
module lv_int_status_agg #(
  parameter int REG_DW   = 8,
  parameter int NUM_REG  = 4,
  parameter int INT_MODE = 0,
  parameter int INT_PW   = 16,
  localparam int IDX_W   = (NUM_REG > 1) ? $clog2(NUM_REG) : 1,
  localparam int TOT_W   = NUM_REG * REG_DW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [TOT_W-1:0]  i_lv_status,
  input  logic [TOT_W-1:0]  i_hv_status,
  input  logic              i_hv_vld,
  input  logic [TOT_W-1:0]  i_mask,
  input  logic              i_clr_vld,
  input  logic [IDX_W-1:0]  i_clr_idx,
  input  logic [REG_DW-1:0] i_clr_data,
  input  logic              i_rd_vld,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [REG_DW-1:0] o_rd_data,
  output logic              o_rd_ack,
  output logic [TOT_W-1:0]  o_flt,
  output logic              o_int
);

  logic [TOT_W-1:0]  hv_shadow;
  logic [TOT_W-1:0]  sticky;
  logic [TOT_W-1:0]  raw;
  logic [TOT_W-1:0]  clr_mask;
  logic [TOT_W-1:0]  sticky_next;
  logic [TOT_W-1:0]  flt_next;
  logic [REG_DW-1:0] rd_word;

  assign raw = i_lv_status | hv_shadow;

  // Indices that do not name a real word match no k, so such clears/reads are no-ops/zero.
  always_comb begin
    clr_mask = '0;
    rd_word  = '0;
    for (int k = 0; k < NUM_REG; k++) begin
      if (i_clr_vld && (i_clr_idx == IDX_W'(k)))
        clr_mask[k*REG_DW +: REG_DW] = i_clr_data;
`ifdef LV_INT_RD_CLR_EN
      if (i_rd_vld && (i_rd_idx == IDX_W'(k)))
        clr_mask[k*REG_DW +: REG_DW] = {REG_DW{1'b1}};
`endif
      if (i_rd_idx == IDX_W'(k))
        rd_word = sticky[k*REG_DW +: REG_DW];
    end
  end

  // Set wins over clear: raw is OR-ed in after the clear mask is applied.
  assign sticky_next = (sticky & ~clr_mask) | raw;
  assign flt_next    = sticky_next & ~i_mask;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hv_shadow <= '0;
      sticky    <= '0;
      o_flt     <= '0;
      o_rd_ack  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      if (i_hv_vld)
        hv_shadow <= i_hv_status;
      sticky   <= sticky_next;
      o_flt    <= flt_next;
      o_rd_ack <= i_rd_vld;
      if (i_rd_vld)
        o_rd_data <= rd_word;
    end
  end

  if (INT_MODE == 0) begin : g_level

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
        o_int <= 1'b0;
      else
        o_int <= |flt_next;
    end

  end else begin : g_pulse

    localparam int CNT_W = $clog2(INT_PW + 1);

    typedef enum logic {
      IDLE,
      PULSE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             new_evt;

    // Only bits newly appearing in the unmasked fault vector count as events.
    assign new_evt = |(flt_next & ~o_flt);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        o_int <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (new_evt) begin
              state <= PULSE;
              cnt   <= CNT_W'(INT_PW);
              o_int <= 1'b1;
            end
          end
          PULSE: begin
            if (new_evt) begin
              cnt <= CNT_W'(INT_PW);
            end else if (cnt == CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
              o_int <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            o_int <= 1'b0;
          end
        endcase
      end
    end

  end

endmodule
